// File: rtl/cla_demo_pkg.sv
// Shared definitions for the adder / BCD / 7-segment display chain.
// DIGIT_W, NUM_DIGITS : BCD digit geometry (three 4-bit digits).
// BCD_BLANK           : digit code the segment decoder renders as all-off.
// conv_state_e        : sequential converter states.
// apply_blank()       : leading-zero suppression of a {hund,tens,ones} word.
package cla_demo_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 3;
  localparam int unsigned SCRATCH_W  = DIGIT_W * NUM_DIGITS;
  localparam logic [DIGIT_W-1:0] BCD_BLANK = 4'hF;

  typedef enum logic {
    IDLE,
    SHIFT
  } conv_state_e;

  // Hundreds blank when zero; tens blank only when hundreds is also zero,
  // so interior zeros survive. Units are never blanked.
  function automatic logic [SCRATCH_W-1:0] apply_blank(input logic [SCRATCH_W-1:0] raw);
    logic [DIGIT_W-1:0] hund;
    logic [DIGIT_W-1:0] tens;
    hund = raw[11:8];
    tens = raw[7:4];
    if (raw[11:8] == '0) begin
      hund = BCD_BLANK;
      if (raw[7:4] == '0) begin
        tens = BCD_BLANK;
      end
    end
    return {hund, tens, raw[3:0]};
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD nibble that is >= 5 so the
// following left shift carries correctly into the next decimal digit.
// Ports:
//   din  - nibble before correction
//   dout - corrected nibble (no carry out; the shift handles propagation)
module bcd_digit_adj
  import cla_demo_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Parameters:
//   WIDTH    - binary input width, 4..9 (max 511 fits three digits)
//   BLANK_LZ - 1: leading zero digits shown as BCD_BLANK; 0: raw digits
// Ports:
//   clk, rst_n - rising-edge clock, asynchronous active-low reset
//   start      - conversion request, honoured only in IDLE
//   bin        - unsigned input value, captured when start is accepted
//   busy       - high while a conversion runs (exactly WIDTH cycles)
//   done       - one-cycle pulse; digit outputs update in this same cycle
//   bcd_ones, bcd_tens, bcd_hund - registered result digits, held between dones
module bcd_seq_converter
  import cla_demo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   bin,
  output logic               busy,
  output logic               done,
  output logic [DIGIT_W-1:0] bcd_ones,
  output logic [DIGIT_W-1:0] bcd_tens,
  output logic [DIGIT_W-1:0] bcd_hund
);

  if (WIDTH < 4 || WIDTH > 9) begin : g_width_check
    $error("bcd_seq_converter: WIDTH must be in 4..9");
  end

  conv_state_e          state_q, state_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic [SCRATCH_W-1:0] scratch_q, scratch_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic [SCRATCH_W-1:0] digits_q, digits_d;

  logic [SCRATCH_W-1:0]       scratch_adj;
  logic [SCRATCH_W+WIDTH-1:0] shifted;

  bcd_digit_adj u_adj_ones (.din(scratch_q[3:0]),  .dout(scratch_adj[3:0]));
  bcd_digit_adj u_adj_tens (.din(scratch_q[7:4]),  .dout(scratch_adj[7:4]));
  bcd_digit_adj u_adj_hund (.din(scratch_q[11:8]), .dout(scratch_adj[11:8]));

  // One double-dabble iteration: corrected scratch and the binary operand
  // shift left together; the operand MSB enters the units nibble.
  assign shifted = {scratch_adj, shift_q} << 1;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    digits_d  = digits_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = bin;
          scratch_d = '0;
          cnt_d     = 4'(WIDTH);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = shifted[SCRATCH_W+WIDTH-1:WIDTH];
        shift_d   = shifted[WIDTH-1:0];
        cnt_d     = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          digits_d = BLANK_LZ ? apply_blank(shifted[SCRATCH_W+WIDTH-1:WIDTH])
                              : shifted[SCRATCH_W+WIDTH-1:WIDTH];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      digits_q  <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      digits_q  <= digits_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign bcd_hund = digits_q[11:8];
  assign bcd_tens = digits_q[7:4];
  assign bcd_ones = digits_q[3:0];

endmodule

// File: doc/bcd_seq_converter.md
Name: bcd_seq_converter

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
- Sits directly downstream of the 8-bit CLA adder and directly upstream of the 7-segment decoders.
- Replaces the combinational divide/modulo converter with one shift per clock and a start/done handshake.
- Optional leading-zero blanking drives the unused digit code that the segment decoder already renders as blank.

Parameters:
- WIDTH, 8: binary input width. Legal range 4..9, so the maximum value 511 fits three digits. Any other value is an elaboration-time error.
- BLANK_LZ, 1: 1 = replace leading zero digits with code 4'hF; 0 = always show raw digits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  conversion request, sampled only in IDLE.
- bin  input  WIDTH  unsigned binary value (adder sum, or {cout,sum} when WIDTH=9). Captured on accepted start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; digit outputs are valid and updated in the same cycle.
- bcd_ones  output  4  units digit, 0..9.
- bcd_tens  output  4  tens digit, 0..9 or 4'hF when blanked.
- bcd_hund  output  4  hundreds digit, 0..5 or 4'hF when blanked.

Behaviour:
- Reset (async assert, synchronous deassert handled upstream):
  - state=IDLE, busy=0, done=0, all three digits=4'h0, scratch registers cleared.
  - Reset during SHIFT aborts the conversion. No done is produced and outputs return to 0.
- States: IDLE, SHIFT.
- IDLE:
  - done is low except during the pulse cycle.
  - On the edge sampling start=1: load shift register with bin, clear the 12-bit BCD scratch, load counter=WIDTH, go to SHIFT, busy->1.
- SHIFT, one iteration per clock:
  - Each scratch nibble >=5 gets +3 (nibble-local, no inter-nibble carry).
  - Then {scratch,shift} shifts left one bit; counter decrements.
- Completion:
  - On the edge where the counter goes 1->0, the final digits (post-shift) are registered onto the outputs.
  - On the same edge: done->1, busy->0, state->IDLE.
- Timing:
  - With start sampled at edge k, done is high during the cycle following edge k+WIDTH.
  - Latency is WIDTH cycles; busy is high for exactly WIDTH cycles.
- Handshake:
  - start while busy=1 is ignored and not queued.
  - start in the done cycle is accepted (state is IDLE), giving back-to-back throughput of one conversion per WIDTH+1 cycles.
  - bin is sampled only at acceptance; later changes have no effect on the running conversion.
- Outputs hold the last result until the next done. Digits never change outside a done cycle or reset.
- Blanking (BLANK_LZ=1), applied when registering outputs:
  - hund==0 -> bcd_hund=4'hF.
  - hund==0 and tens==0 -> bcd_tens=4'hF.
  - bcd_ones is never blanked.
  - Interior zeros (e.g. 105) are never blanked.
  - The reset value is not blanked (all 0).
- Arithmetic: the scratch is 12 bits regardless of WIDTH. The counter is 4 bits and wide enough for 9.

Decomposition:
- Shared package cla_demo_pkg holds:
  - DIGIT_W=4, BCD_BLANK=4'hF, NUM_DIGITS=3.
  - The state enum (IDLE, SHIFT).
  - The same package is to be used by the segment decoder for the blank code.
- One sub-module: bcd_digit_adj. It is a 4-bit combinational add-3-if-≥5 and is instantiated three times.

Test Plan:
- WIDTH=8, BLANK_LZ=1, bin=255, start pulse -> busy high 8 cycles; done pulse in the cycle after edge k+8; outputs hund=2, tens=5, ones=5.
- bin=0 -> outputs F,F,0. Repeat with BLANK_LZ=0 -> 0,0,0. Then bin=7 -> F,F,7; bin=105 -> 1,0,5 (interior zero kept).
- Start at k with bin=200; assert start again at k+3 with bin=99 -> only one done; outputs 2,0,0; second request dropped.
- Back-to-back: start with 123, then start again in the done cycle with 45 -> done pulses exactly 9 cycles apart; outputs 1,2,3 then F,4,5.
- Reset mid-conversion: start with 255, drop rst_n at k+4 -> busy/done/digits go 0 immediately (async). After release, no done appears until a new start.
- WIDTH=9 build: bin=511 -> 5,1,1 after 9 cycles. Elaborating with WIDTH=10 must fail.
